// File: rtl/cache_types.sv
// Shared types and address-field helpers for the direct-mapped L1 cache.
package cache_types;

    localparam int S_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    // Line viewed as 8 words of 4 bytes each.
    typedef logic [7:0][3:0][7:0] line_t;

    function automatic logic [31:0] get_tag(input logic [31:0] a,
                                            input int s_index);
        return a >> (S_OFFSET + s_index);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] a,
                                              input int s_index);
        return (a >> S_OFFSET) & ((32'd1 << s_index) - 32'd1);
    endfunction

    function automatic logic [2:0] get_word(input logic [31:0] a);
        return a[4:2];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Per-set storage with combinational read and clocked write.
module cache_array #(
    parameter int WIDTH       = 1,
    parameter int S_INDEX     = 3,
    parameter bit RESET_CLEAR = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [S_INDEX-1:0] index,
    input  logic [WIDTH-1:0]   datain,
    output logic [WIDTH-1:0]   dataout
);

    localparam int DEPTH = 2 ** S_INDEX;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (RESET_CLEAR && reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            mem_q[index] <= datain;
        end
    end

    assign dataout = mem_q[index];

endmodule

// File: rtl/l1_direct_cache.sv
// Direct-mapped write-back/write-allocate L1 cache: FSM and byte merge.
module l1_direct_cache
    import cache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_mbe,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int S_TAG = 32 - S_OFFSET - S_INDEX;

    cache_state_t state_q, state_d;

    logic [S_TAG-1:0]   addr_tag;
    logic [S_INDEX-1:0] idx;
    logic [2:0]         word;

    logic               valid_out, valid_in, valid_load;
    logic               dirty_out, dirty_in, dirty_load;
    logic [S_TAG-1:0]   tag_out;
    logic               tag_load;
    line_t              data_out, data_in, merged;
    logic               data_load;

    logic               hit, req;
    logic               unused_addr;

    assign addr_tag    = S_TAG'(get_tag(mem_address, S_INDEX));
    assign idx         = S_INDEX'(get_index(mem_address, S_INDEX));
    assign word        = get_word(mem_address);
    assign unused_addr = ^mem_address[1:0];

    assign hit = valid_out && (tag_out == addr_tag);
    assign req = mem_read || mem_write;

    assign mem_rdata  = data_out[word];
    assign pmem_wdata = data_out;

    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESET_CLEAR(1'b1)) u_valid (
        .clk     (clk),
        .reset   (reset),
        .load    (valid_load && !reset),
        .index   (idx),
        .datain  (valid_in),
        .dataout (valid_out)
    );

    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESET_CLEAR(1'b1)) u_dirty (
        .clk     (clk),
        .reset   (reset),
        .load    (dirty_load && !reset),
        .index   (idx),
        .datain  (dirty_in),
        .dataout (dirty_out)
    );

    cache_array #(.WIDTH(S_TAG), .S_INDEX(S_INDEX)) u_tag (
        .clk     (clk),
        .reset   (reset),
        .load    (tag_load && !reset),
        .index   (idx),
        .datain  (addr_tag),
        .dataout (tag_out)
    );

    cache_array #(.WIDTH(256), .S_INDEX(S_INDEX)) u_data (
        .clk     (clk),
        .reset   (reset),
        .load    (data_load && !reset),
        .index   (idx),
        .datain  (data_in),
        .dataout (data_out)
    );

    always_comb begin
        merged = data_out;
        for (int b = 0; b < 4; b++) begin
            if (mem_mbe[b]) begin
                merged[word][b] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        valid_in     = 1'b0;
        valid_load   = 1'b0;
        dirty_in     = 1'b0;
        dirty_load   = 1'b0;
        tag_load     = 1'b0;
        data_in      = merged;
        data_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    // A write wins when both request lines are high.
                    if (mem_write) begin
                        data_load  = 1'b1;
                        dirty_in   = 1'b1;
                        dirty_load = 1'b1;
                    end
                end else if (req) begin
                    if (valid_out && dirty_out) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, idx, 5'b0};
                if (pmem_resp) begin
                    dirty_load = 1'b1;
                    state_d    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
                if (pmem_resp) begin
                    data_in    = pmem_rdata;
                    data_load  = 1'b1;
                    tag_load   = 1'b1;
                    valid_in   = 1'b1;
                    valid_load = 1'b1;
                    dirty_load = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset forces the memory-facing handshake idle in its own cycle.
        if (reset) begin
            mem_resp     = 1'b0;
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = '0;
        end
    end

endmodule
